// File: rtl/ahb_slv_pkg.sv
// Shared encodings, FSM state type and byte-lane decode for the AHB-Lite memory slave.
// Pure definitions: no latency, no flow control.
package ahb_slv_pkg;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Oversized transfers fall through to a full-word enable; halfwords align on lane[1].
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << lane;
            HSIZE_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: byte_en = 4'b1111;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slv_mem_array.sv
// DEPTH x 32 word store with per-byte write enables and a combinational read port.
// Write lands on the clock edge; read reflects the array immediately. No backpressure.
module ahb_slv_mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory responder: WAIT_STATES data-phase stalls per OKAY transfer, pipelined accepts.
// Stalls via HREADYOUT; AHB_SLV_ERR_EN adds the two-cycle ERROR response for bad address/size.
module ahb_lite_mem_slave
    import ahb_slv_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                state, state_nxt;
    logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
    logic [AW-1:0]         cap_word;
    logic [1:0]            cap_lane;
    logic [2:0]            cap_size;
    logic                  cap_write;
    logic                  slot_free;
    logic                  accept;
    logic                  addr_err;
    logic [3:0]            mem_we;
    logic [31:0]           mem_rdata;
    logic                  unused_addr;

    assign slot_free = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept    = HSEL && HREADY && slot_free &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

`ifdef AHB_SLV_ERR_EN
    assign addr_err = (HADDR >= 32'(DEPTH * 4)) ||
                      (HSIZE > HSIZE_WORD) ||
                      ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (|HADDR[1:0]));
    assign HRESP    = (state == ST_ERR1) || (state == ST_ERR2);
`else
    assign addr_err = 1'b0;
    assign HRESP    = 1'b0;
`endif

    // Upper address bits only matter to the range check.
    assign unused_addr = ^HADDR;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt == '0) state_nxt = ST_DATA;
                else           cnt_nxt   = cnt - 1'b1;
            end
`ifdef AHB_SLV_ERR_EN
            ST_ERR1: state_nxt = ST_ERR2;
`endif
            default: begin
                if (!accept) begin
                    state_nxt = ST_IDLE;
                end else if (addr_err) begin
                    state_nxt = ST_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_word  <= '0;
            cap_lane  <= '0;
            cap_size  <= '0;
            cap_write <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_word  <= HADDR[2 +: AW];
                cap_lane  <= HADDR[1:0];
                cap_size  <= HSIZE;
                cap_write <= HWRITE;
            end
        end
    end

    // Commit on the edge that closes the write data phase, unless reset lands on that edge.
    assign mem_we = (HRESETn && (state == ST_DATA) && cap_write) ?
                    byte_en(cap_size, cap_lane) : 4'b0000;

    ahb_slv_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .addr  (cap_word),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
    assign HRDATA    = (((state == ST_WAIT) || (state == ST_DATA)) && !cap_write) ?
                       mem_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench: one zero-wait and one three-wait slave share the bus signals, each with its own select.
module tb_ahb_lite_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel0, sel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        rdy0, resp0, rdy3, resp3;
    logic [31:0] rdata0, rdata3;

    int n_cmp = 0;
    int n_err = 0;
    int nw;

    always #5 clk = ~clk;

    ahb_lite_mem_slave #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(rdy0), .HWDATA(hwdata),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_lite_mem_slave #(.DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(rdy3), .HWDATA(hwdata),
        .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic addr_ph(input logic s0, input logic s3, input logic [31:0] a,
                           input logic w, input logic [2:0] sz);
        sel0   = s0;
        sel3   = s3;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = 2'b10;
    endtask

    task automatic idle_ph();
        sel0   = 1'b0;
        sel3   = 1'b0;
        htrans = 2'b00;
    endtask

    // Called at a negedge; returns at the first negedge where the 3-wait slave is ready.
    task automatic wait_rdy3(output int n);
        n = 0;
        while (!rdy3 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        hwdata = 32'h0;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd2;
        idle_ph();
        repeat (3) @(negedge clk);

        chk("rst_rdy0",   {31'h0, rdy0},  32'h1);
        chk("rst_resp0",  {31'h0, resp0}, 32'h0);
        chk("rst_rdata0", rdata0,         32'h0);
        chk("rst_rdy3",   {31'h0, rdy3},  32'h1);
        chk("rst_resp3",  {31'h0, resp3}, 32'h0);
        chk("rst_rdata3", rdata3,         32'h0);
        rst_n = 1'b1;

        // zero-wait write then read
        addr_ph(1, 0, 32'h10, 1, 3'd2);
        @(negedge clk);
        chk("t1_wr_rdy", {31'h0, rdy0}, 32'h1);
        hwdata = 32'hDEADBEEF;
        addr_ph(1, 0, 32'h10, 0, 3'd2);
        @(negedge clk);
        chk("t1_rd_rdy",  {31'h0, rdy0}, 32'h1);
        chk("t1_rd_data", rdata0, 32'hDEADBEEF);
        idle_ph();
        @(negedge clk);
        chk("t1_idle_data", rdata0, 32'h0);

        // three wait states
        addr_ph(0, 1, 32'h30, 1, 3'd2);
        @(negedge clk);
        hwdata = 32'h12345678;
        idle_ph();
        wait_rdy3(nw);
        chk("t2_wr_waits", nw, 32'd3);
        addr_ph(0, 1, 32'h30, 0, 3'd2);
        @(negedge clk);
        chk("t2_rd_wait_resp", {31'h0, resp3}, 32'h0);
        idle_ph();
        wait_rdy3(nw);
        chk("t2_rd_waits", nw, 32'd3);
        chk("t2_rd_resp",  {31'h0, resp3}, 32'h0);
        chk("t2_rd_data",  rdata3, 32'h12345678);
        @(negedge clk);
        chk("t2_idle_rdy",  {31'h0, rdy3}, 32'h1);
        chk("t2_idle_data", rdata3, 32'h0);

        // byte and halfword lanes, fully pipelined
        addr_ph(1, 0, 32'h20, 1, 3'd2);
        @(negedge clk);
        hwdata = 32'hAABBCCDD;
        addr_ph(1, 0, 32'h20, 1, 3'd0);
        @(negedge clk);
        hwdata = 32'h00000011;
        addr_ph(1, 0, 32'h21, 1, 3'd0);
        @(negedge clk);
        hwdata = 32'h00002200;
        addr_ph(1, 0, 32'h20, 0, 3'd2);
        @(negedge clk);
        chk("t3_bytes", rdata0, 32'hAABB2211);
        addr_ph(1, 0, 32'h22, 1, 3'd1);
        @(negedge clk);
        hwdata = 32'hBEEF0000;
        addr_ph(1, 0, 32'h20, 0, 3'd2);
        @(negedge clk);
        chk("t3_half", rdata0, 32'hBEEF2211);

        // write then read of the same word with no idle between
        addr_ph(1, 0, 32'h0, 1, 3'd2);
        @(negedge clk);
        hwdata = 32'hCAFEF00D;
        addr_ph(1, 0, 32'h0, 0, 3'd2);
        @(negedge clk);
        chk("t5_raw", rdata0, 32'hCAFEF00D);
        idle_ph();
        @(negedge clk);

`ifdef AHB_SLV_ERR_EN
        addr_ph(1, 0, 32'h1000, 0, 3'd2);
        @(negedge clk);
        chk("t4_err1_rdy",  {31'h0, rdy0},  32'h0);
        chk("t4_err1_resp", {31'h0, resp0}, 32'h1);
        chk("t4_err1_data", rdata0,         32'h0);
        idle_ph();
        @(negedge clk);
        chk("t4_err2_rdy",  {31'h0, rdy0},  32'h1);
        chk("t4_err2_resp", {31'h0, resp0}, 32'h1);
        @(negedge clk);
        chk("t4_okay_resp", {31'h0, resp0}, 32'h0);
        addr_ph(1, 0, 32'h2, 1, 3'd2);
        @(negedge clk);
        hwdata = 32'hFFFFFFFF;
        chk("t4_mis_resp", {31'h0, resp0}, 32'h1);
        idle_ph();
        @(negedge clk);
        addr_ph(1, 0, 32'h0, 0, 3'd2);
        @(negedge clk);
        chk("t4_no_commit", rdata0, 32'hCAFEF00D);
`else
        addr_ph(1, 0, 32'h1000, 0, 3'd2);
        @(negedge clk);
        chk("t4_wrap_resp", {31'h0, resp0}, 32'h0);
        chk("t4_wrap_data", rdata0, 32'hCAFEF00D);
        addr_ph(1, 0, 32'h2, 0, 3'd2);
        @(negedge clk);
        chk("t4_mis_data", rdata0, 32'hCAFEF00D);
`endif
        idle_ph();
        @(negedge clk);

        // reset in the middle of a waited write aborts it
        addr_ph(0, 1, 32'h30, 1, 3'd2);
        @(negedge clk);
        hwdata = 32'h0;
        idle_ph();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_rdy",  {31'h0, rdy3},  32'h1);
        chk("t6_rst_resp", {31'h0, resp3}, 32'h0);
        rst_n = 1'b1;
        addr_ph(0, 1, 32'h30, 0, 3'd2);
        @(negedge clk);
        idle_ph();
        wait_rdy3(nw);
        chk("t6_rd_waits", nw, 32'd3);
        chk("t6_word_kept", rdata3, 32'h12345678);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
